// File: rtl/dir_pkg.sv
// Opcode and line-state encodings shared between the directory and the cache responders.
package dir_pkg;

   localparam int unsigned OP_W = 3;
   localparam int unsigned ST_W = 2;

   typedef enum logic [OP_W-1:0] {
      OP_NOOP  = 3'd0,
      OP_REPLY = 3'd2,
      OP_RD    = 3'd3,
      OP_WR    = 3'd4,
      OP_INV   = 3'd5,
      OP_UPD   = 3'd6,
      OP_RINV  = 3'd7
   } dir_op_e;

   // Line states: bit1 = modified, bit0 = shared; 2'b11 is treated as modified.
   localparam logic [ST_W-1:0] ST_INV = 2'b00;
   localparam logic [ST_W-1:0] ST_SHR = 2'b01;
   localparam logic [ST_W-1:0] ST_MOD = 2'b10;

   function automatic logic is_modified(input logic [ST_W-1:0] st);
      return st[1];
   endfunction

   function automatic logic is_shared(input logic [ST_W-1:0] st);
      return !st[1] && st[0];
   endfunction

   // Action chosen for one request after its lookup has returned.
   typedef struct packed {
      logic            reply;
      dir_op_e         rsp_op;
      logic            use_lu_data;
      logic            st_wr;
      logic [ST_W-1:0] st_state;
      logic            line_wr;
   } dir_action_t;

endpackage

// File: rtl/dir_rsp_decode.sv
// Maps (opcode, lookup hit, line state) to the responder's action.
import dir_pkg::*;

module dir_rsp_decode (
   input  logic [OP_W-1:0] op,
   input  logic            hit,
   input  logic [ST_W-1:0] state,
   output dir_action_t     act
);

   logic hit_mod;
   logic hit_shr;

   assign hit_mod = hit && is_modified(state);
   assign hit_shr = hit && is_shared(state);

   // Action table; anything not listed is consumed silently.
   always_comb begin
      act        = '0;
      act.rsp_op = OP_NOOP;
      case (dir_op_e'(op))
         OP_RD: begin
            act.reply = 1'b1;
            if (hit) begin
               act.rsp_op      = OP_REPLY;
               act.use_lu_data = 1'b1;
               if (hit_mod) begin
                  act.st_wr    = 1'b1;
                  act.st_state = ST_SHR;
               end
            end
         end
         OP_WR: begin
            act.line_wr  = 1'b1;
            act.st_wr    = 1'b1;
            act.st_state = ST_SHR;
         end
         OP_INV: begin
            if (hit_mod) begin
               act.reply       = 1'b1;
               act.rsp_op      = OP_WR;
               act.use_lu_data = 1'b1;
               act.st_wr       = 1'b1;
               act.st_state    = ST_INV;
            end else if (hit_shr) begin
               act.st_wr    = 1'b1;
               act.st_state = ST_INV;
            end
         end
         OP_UPD: begin
            if (hit_shr) begin
               act.st_wr    = 1'b1;
               act.st_state = ST_MOD;
            end
         end
         OP_RINV: begin
            act.reply = 1'b1;
            if (hit) begin
               act.rsp_op      = OP_REPLY;
               act.use_lu_data = 1'b1;
               act.st_wr       = 1'b1;
               act.st_state    = ST_INV;
            end
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/cache_dir_responder.sv
// Services directory requests against the local cache: lookup, state/data update, optional reply.
import dir_pkg::*;

module cache_dir_responder #(
   parameter int unsigned CL_SIZE = 128,
   parameter int unsigned NAME    = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               req_valid,
   output logic               req_ready,
   input  logic [2:0]         req_operation,
   input  logic [31:0]        req_addr,
   input  logic [CL_SIZE-1:0] req_data,
   output logic               lu_req,
   output logic [31:0]        lu_addr,
   input  logic               lu_hit,
   input  logic [1:0]         lu_state,
   input  logic [CL_SIZE-1:0] lu_data,
   output logic               st_wr_en,
   output logic [31:0]        st_wr_addr,
   output logic [1:0]         st_wr_state,
   output logic               line_wr_en,
   output logic [CL_SIZE-1:0] line_wr_data,
   output logic               rsp_valid,
   input  logic               rsp_ready,
   output logic [2:0]         rsp_operation,
   output logic [31:0]        rsp_addr,
   output logic [CL_SIZE-1:0] rsp_data,
   output logic [1:0]         rsp_src,
   output logic               busy
);

   localparam int unsigned AW = 32;

   typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_EVAL, S_SEND} state_e;

   state_e              state_q, state_d;
   logic [OP_W-1:0]     op_q;
   logic [AW-1:0]       addr_q;
   logic [CL_SIZE-1:0]  data_q;
   dir_action_t         act;
   logic                accept;
   logic                eval_go;
   logic                send_done;

   dir_rsp_decode u_decode (
      .op    (op_q),
      .hit   (lu_hit),
      .state (lu_state),
      .act   (act)
   );

   assign rsp_src = 2'(NAME);

   // Next-state logic.
   always_comb begin
      state_d   = state_q;
      accept    = 1'b0;
      eval_go   = 1'b0;
      send_done = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (req_valid && req_ready) begin
               accept  = 1'b1;
               state_d = S_LOOKUP;
            end
         end
         S_LOOKUP: state_d = S_EVAL;
         S_EVAL: begin
            eval_go = 1'b1;
            state_d = act.reply ? S_SEND : S_IDLE;
         end
         S_SEND: begin
            if (rsp_ready) begin
               send_done = 1'b1;
               state_d   = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= S_IDLE;
      else      state_q <= state_d;
   end

   // Request capture at accept.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         op_q   <= '0;
         addr_q <= '0;
         data_q <= '0;
      end else if (accept) begin
         op_q   <= req_operation;
         addr_q <= req_addr;
         data_q <= req_data;
      end
   end

   // Registered outputs, derived from the upcoming state and the EVAL decision.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         req_ready     <= 1'b0;
         busy          <= 1'b0;
         lu_req        <= 1'b0;
         lu_addr       <= '0;
         st_wr_en      <= 1'b0;
         st_wr_addr    <= '0;
         st_wr_state   <= '0;
         line_wr_en    <= 1'b0;
         line_wr_data  <= '0;
         rsp_valid     <= 1'b0;
         rsp_operation <= '0;
         rsp_addr      <= '0;
         rsp_data      <= '0;
      end else begin
         req_ready  <= (state_d == S_IDLE);
         busy       <= (state_d != S_IDLE);
         lu_req     <= accept;
         lu_addr    <= accept ? req_addr : '0;
         st_wr_en   <= eval_go && act.st_wr;
         line_wr_en <= eval_go && act.line_wr;
         if (eval_go && act.st_wr) begin
            st_wr_addr  <= addr_q;
            st_wr_state <= act.st_state;
         end
         if (eval_go && act.line_wr) line_wr_data <= data_q;
         if (eval_go && act.reply) begin
            rsp_valid     <= 1'b1;
            rsp_operation <= act.rsp_op;
            rsp_addr      <= addr_q;
            rsp_data      <= act.use_lu_data ? lu_data : '0;
         end else if (send_done) begin
            rsp_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_cache_dir_responder.sv
// Randomized and directed bench for cache_dir_responder with a rule-level reference model.
module tb_cache_dir_responder;

   localparam int unsigned CL = 128;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic [2:0]    req_operation = '0;
   logic [31:0]   req_addr = '0;
   logic [CL-1:0] req_data = '0;
   logic          lu_req;
   logic [31:0]   lu_addr;
   logic          lu_hit = 1'b0;
   logic [1:0]    lu_state = '0;
   logic [CL-1:0] lu_data = '0;
   logic          st_wr_en;
   logic [31:0]   st_wr_addr;
   logic [1:0]    st_wr_state;
   logic          line_wr_en;
   logic [CL-1:0] line_wr_data;
   logic          rsp_valid;
   logic          rsp_ready = 1'b0;
   logic [2:0]    rsp_operation;
   logic [31:0]   rsp_addr;
   logic [CL-1:0] rsp_data;
   logic [1:0]    rsp_src;
   logic          busy;

   int checks = 0;
   int errors = 0;

   cache_dir_responder #(.CL_SIZE(CL), .NAME(1)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_operation(req_operation),
      .req_addr(req_addr), .req_data(req_data),
      .lu_req(lu_req), .lu_addr(lu_addr), .lu_hit(lu_hit), .lu_state(lu_state), .lu_data(lu_data),
      .st_wr_en(st_wr_en), .st_wr_addr(st_wr_addr), .st_wr_state(st_wr_state),
      .line_wr_en(line_wr_en), .line_wr_data(line_wr_data),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_operation(rsp_operation),
      .rsp_addr(rsp_addr), .rsp_data(rsp_data), .rsp_src(rsp_src), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [CL-1:0] got, input logic [CL-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference behaviour written straight from the opcode rules.
   function automatic void model(input logic [2:0] op, input logic hit, input logic [1:0] st,
                                 input logic [CL-1:0] lud,
                                 output logic rep, output logic [2:0] rop, output logic [CL-1:0] rdat,
                                 output logic stw, output logic [1:0] sts, output logic lw);
      logic modified;
      logic shared;
      modified = hit && st[1];
      shared   = hit && (st == 2'b01);
      rep = 0; rop = 0; rdat = '0; stw = 0; sts = 0; lw = 0;
      case (op)
         3'd3: begin
            rep = 1;
            if (hit) begin
               rop = 3'd2; rdat = lud;
               if (modified) begin stw = 1; sts = 2'b01; end
            end
         end
         3'd4: begin lw = 1; stw = 1; sts = 2'b01; end
         3'd5: begin
            if (modified) begin rep = 1; rop = 3'd4; rdat = lud; stw = 1; sts = 2'b00; end
            else if (shared) begin stw = 1; sts = 2'b00; end
         end
         3'd6: if (shared) begin stw = 1; sts = 2'b10; end
         3'd7: begin
            rep = 1;
            if (hit) begin rop = 3'd2; rdat = lud; stw = 1; sts = 2'b00; end
         end
         default: ;
      endcase
   endfunction

   task automatic run_txn(input logic [2:0] op, input logic [31:0] addr, input logic [CL-1:0] wdata,
                          input logic hit, input logic [1:0] st, input logic [CL-1:0] lud,
                          input int hold);
      logic rep, stw, lw;
      logic [2:0] rop;
      logic [1:0] sts;
      logic [CL-1:0] rdat;
      model(op, hit, st, lud, rep, rop, rdat, stw, sts, lw);
      @(negedge clk);
      check_eq("req_ready_idle", CL'(req_ready), CL'(1));
      lu_hit = hit; lu_state = st; lu_data = lud;
      req_valid = 1'b1; req_operation = op; req_addr = addr; req_data = wdata;
      @(posedge clk);
      #1 req_valid = 1'b0;
      req_addr = $urandom; req_data = {4{$urandom}};
      @(negedge clk);
      check_eq("lu_req", CL'(lu_req), CL'(1));
      check_eq("lu_addr", CL'(lu_addr), CL'(addr));
      check_eq("busy", CL'(busy), CL'(1));
      check_eq("req_ready_lookup", CL'(req_ready), CL'(0));
      @(negedge clk);
      check_eq("lu_req_once", CL'(lu_req), CL'(0));
      check_eq("st_wr_early", CL'(st_wr_en), CL'(0));
      check_eq("rsp_valid_early", CL'(rsp_valid), CL'(0));
      @(negedge clk);
      check_eq("st_wr_en", CL'(st_wr_en), CL'(stw));
      if (stw) begin
         check_eq("st_wr_state", CL'(st_wr_state), CL'(sts));
         check_eq("st_wr_addr", CL'(st_wr_addr), CL'(addr));
      end
      check_eq("line_wr_en", CL'(line_wr_en), CL'(lw));
      if (lw) check_eq("line_wr_data", line_wr_data, wdata);
      check_eq("rsp_valid", CL'(rsp_valid), CL'(rep));
      check_eq("req_ready_after", CL'(req_ready), CL'(!rep));
      if (rep) begin
         check_eq("rsp_operation", CL'(rsp_operation), CL'(rop));
         check_eq("rsp_data", rsp_data, rdat);
         check_eq("rsp_addr", CL'(rsp_addr), CL'(addr));
         check_eq("rsp_src", CL'(rsp_src), CL'(1));
         for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check_eq("hold_valid", CL'(rsp_valid), CL'(1));
            check_eq("hold_op", CL'(rsp_operation), CL'(rop));
            check_eq("hold_data", rsp_data, rdat);
            check_eq("hold_addr", CL'(rsp_addr), CL'(addr));
            check_eq("hold_req_ready", CL'(req_ready), CL'(0));
            check_eq("hold_st_wr", CL'(st_wr_en), CL'(0));
         end
         rsp_ready = 1'b1;
         @(posedge clk);
         #1 rsp_ready = 1'b0;
         @(negedge clk);
         check_eq("rsp_done_valid", CL'(rsp_valid), CL'(0));
         check_eq("rsp_done_ready", CL'(req_ready), CL'(1));
         check_eq("rsp_done_busy", CL'(busy), CL'(0));
      end else begin
         check_eq("no_rsp_busy", CL'(busy), CL'(0));
      end
   endtask

   initial begin
      logic [CL-1:0] a5;
      a5 = {16{8'hA5}};
      repeat (2) @(negedge clk);
      check_eq("rst_req_ready", CL'(req_ready), CL'(0));
      check_eq("rst_busy", CL'(busy), CL'(0));
      check_eq("rst_rsp_valid", CL'(rsp_valid), CL'(0));
      check_eq("rst_lu_req", CL'(lu_req), CL'(0));
      check_eq("rst_st_wr", CL'(st_wr_en), CL'(0));
      check_eq("rst_rsp_src", CL'(rsp_src), CL'(1));
      rst = 1'b1;
      @(negedge clk);
      check_eq("rel_req_ready", CL'(req_ready), CL'(1));

      run_txn(3'd3, 32'h40, '0, 1'b1, 2'b10, a5, 0);
      run_txn(3'd5, 32'h80, '0, 1'b1, 2'b10, {4{32'hDEADBEEF}}, 1);
      run_txn(3'd5, 32'h84, '0, 1'b1, 2'b01, {4{32'h11112222}}, 0);
      run_txn(3'd7, 32'hC0, '0, 1'b0, 2'b10, {4{32'h55555555}}, 0);
      run_txn(3'd3, 32'h100, '0, 1'b1, 2'b01, {4{32'hCAFEF00D}}, 5);
      run_txn(3'd4, 32'h140, CL'(32'h1234), 1'b0, 2'b00, '0, 0);
      run_txn(3'd6, 32'h180, '0, 1'b1, 2'b01, '0, 0);
      run_txn(3'd3, 32'h1C0, '0, 1'b1, 2'b11, a5, 0);
      run_txn(3'd0, 32'h200, '0, 1'b1, 2'b10, a5, 0);

      // Reset while a reply is pending in SEND.
      @(negedge clk);
      lu_hit = 1'b1; lu_state = 2'b01; lu_data = a5;
      req_valid = 1'b1; req_operation = 3'd3; req_addr = 32'h240;
      @(posedge clk);
      #1 req_valid = 1'b0;
      repeat (3) @(negedge clk);
      check_eq("pre_rst_rsp_valid", CL'(rsp_valid), CL'(1));
      #2 rst = 1'b0;
      #1;
      check_eq("async_rsp_valid", CL'(rsp_valid), CL'(0));
      check_eq("async_busy", CL'(busy), CL'(0));
      check_eq("async_st_wr", CL'(st_wr_en), CL'(0));
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check_eq("post_rst_busy", CL'(busy), CL'(0));
      check_eq("post_rst_ready", CL'(req_ready), CL'(1));
      check_eq("post_rst_rsp_valid", CL'(rsp_valid), CL'(0));

      for (int n = 0; n < 60; n++) begin
         run_txn(3'($urandom_range(0, 7)), $urandom, {4{$urandom}}, 1'($urandom_range(0, 1)),
                 2'($urandom_range(0, 3)), {4{$urandom}}, $urandom_range(0, 3));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
